mix_columns_seq: RTL and testbench

Column-serial MixColumns engine and sequencer for the AES-128 round datapath. It accepts a 128-bit state over a valid/ready handshake and pushes the four 32-bit columns, one per cycle, through a single shared column mixer. It then presents the mixed state on a valid/ready output. It replaces the fully parallel 16-byte mixer where area matters more than throughput, and sits between ShiftRows and AddRoundKey in the round loop.

---
 rtl/mix_columns_seq.sv | 142 ++++++++++++++
 tb/tb_mix_columns_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns engine: one shared column mixer, four columns per state.
// Define MIX_COLUMNS_INV_EN to build the InvMixColumns datapath and honour in_inv.
module mix_columns_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [1:0]     col;
    logic [127:0]   st;
    logic           inv;
    logic           accept;
    logic [31:0]    col_in;
    logic [31:0]    col_mixed;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = c[7:0];
        a1 = c[15:8];
        a2 = c[23:16];
        a3 = c[31:24];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b3, b2, b1, b0};
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    // Multiples 09/0b/0d/0e built from a shared xtime chain (x2, x4, x8).
    function automatic logic [31:0] mul_set(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return {x8 ^ x4 ^ x2, x8 ^ x4 ^ x, x8 ^ x2 ^ x, x8 ^ x};
    endfunction

    function automatic logic [31:0] mix_inv(input logic [31:0] c);
        logic [31:0] m0, m1, m2, m3;
        logic [7:0]  b0, b1, b2, b3;
        // Each m holds {0e*a, 0d*a, 0b*a, 09*a} for one row byte.
        m0 = mul_set(c[7:0]);
        m1 = mul_set(c[15:8]);
        m2 = mul_set(c[23:16]);
        m3 = mul_set(c[31:24]);
        b0 = m0[31:24] ^ m1[15:8]  ^ m2[23:16] ^ m3[7:0];
        b1 = m0[7:0]   ^ m1[31:24] ^ m2[15:8]  ^ m3[23:16];
        b2 = m0[23:16] ^ m1[7:0]   ^ m2[31:24] ^ m3[15:8];
        b3 = m0[15:8]  ^ m1[23:16] ^ m2[7:0]   ^ m3[31:24];
        return {b3, b2, b1, b0};
    endfunction
`endif

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);
    assign out_data  = st;
    assign col_in    = st[{col, 5'b00000} +: 32];

`ifdef MIX_COLUMNS_INV_EN
    assign col_mixed = inv ? mix_inv(col_in) : mix_fwd(col_in);
`else
    logic unused_inv;
    assign unused_inv = ^{in_inv, inv};
    assign col_mixed  = mix_fwd(col_in);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (col == 2'd3) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_next = BUSY;
                end else if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Working register: loaded on accept, then one column rewritten in place per BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= 128'd0;
            col <= 2'd0;
            inv <= 1'b0;
        end else if (accept) begin
            st  <= in_data;
            col <= 2'd0;
`ifdef MIX_COLUMNS_INV_EN
            inv <= in_inv;
`else
            inv <= 1'b0;
`endif
        end else if (state == BUSY) begin
            st[{col, 5'b00000} +: 32] <= col_mixed;
            col                       <= col + 2'd1;
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Randomized self-checking bench for mix_columns_seq against a matrix-form GF(2^8) model.
module tb_mix_columns_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int checks   = 0;
    int failures = 0;

`ifdef MIX_COLUMNS_INV_EN
    localparam bit INV_BUILT = 1'b1;
`else
    localparam bit INV_BUILT = 1'b0;
`endif

    mix_columns_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_inv   (in_inv),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Generic shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Circulant matrix product per column: b_r = XOR_k coef[(k-r) mod 4] * a_k.
    function automatic logic [127:0] refMix(input logic [127:0] d, input logic inv);
        logic [7:0]   coef [4];
        logic [127:0] r;
        logic [7:0]   acc;
        if (inv && INV_BUILT) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gmul(coef[(k - row + 4) % 4], d[32*c + 8*k +: 8]);
                end
                r[32*c + 8*row +: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] randState();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a state and returns once it has been accepted (bounded wait).
    task automatic applyStimulus(input logic [127:0] d, input logic inv);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        for (int i = 0; i < 20 && !done; i++) begin
            done = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!done) checkOutput("accept_timeout", 128'd0, 128'd1);
    endtask

    task automatic waitOutValid(input string tag);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        checkOutput(tag, {127'd0, out_valid}, 128'd1);
    endtask

    logic [127:0] fips_in;
    logic [127:0] fips_out;
    logic [127:0] a_st;
    logic [127:0] b_st;
    logic [127:0] held;
    logic [127:0] stim [8];
    logic [127:0] expq [$];
    int           idx;
    int           outs;
    int           last_acc;
    bit           will_acc;

    initial begin
        fips_in  = 128'hc6c6c6c6_01010101_5c220af2_455313db;
        fips_out = 128'hc6c6c6c6_01010101_9d58dc9f_bca14d8e;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_inv    = 1'b0;
        out_ready = 1'b0;
        #3;
        checkOutput("rst_in_ready",  {127'd0, in_ready},  128'd1);
        checkOutput("rst_out_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("rst_out_data",  out_data,            128'd0);
        checkOutput("rst_busy",      {127'd0, busy},      128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Forward FIPS vector with exact latency check.
        checkOutput("model_fips", refMix(fips_in, 1'b0), fips_out);
        applyStimulus(fips_in, 1'b0);
        checkOutput("fwd_busy", {127'd0, busy}, 128'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkOutput($sformatf("fwd_latency_%0d", i), {127'd0, out_valid}, {127'd0, (i == 4)});
        end
        checkOutput("fwd_data", out_data, fips_out);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("fwd_drained", {127'd0, out_valid}, 128'd0);

        // Inverse vector (forward mix when inverse is not built).
        applyStimulus(fips_out, 1'b1);
        waitOutValid("inv_valid");
        checkOutput("inv_data", out_data, INV_BUILT ? fips_in : refMix(fips_out, 1'b0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Backpressure in DONE, then same-cycle consume and accept.
        a_st = randState();
        b_st = randState();
        applyStimulus(a_st, 1'($urandom_range(0, 1)));
        waitOutValid("bp_valid");
        held = out_data;
        checkOutput("bp_data", held, refMix(a_st, in_inv));
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("bp_hold_valid", {127'd0, out_valid}, 128'd1);
            checkOutput("bp_hold_data", out_data, held);
            checkOutput("bp_hold_ready", {127'd0, in_ready}, 128'd0);
        end
        in_valid  = 1'b1;
        in_data   = b_st;
        in_inv    = 1'b0;
        out_ready = 1'b1;
        #1;
        checkOutput("bp_ready_up", {127'd0, in_ready}, 128'd1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("bp_busy_next", {127'd0, busy}, 128'd1);
        checkOutput("bp_valid_drop", {127'd0, out_valid}, 128'd0);
        waitOutValid("bp2_valid");
        checkOutput("bp2_data", out_data, refMix(b_st, 1'b0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Input pulsed during BUSY must not disturb the in-flight state.
        a_st = randState();
        applyStimulus(a_st, 1'b0);
        in_valid = 1'b1;
        in_data  = randState();
        in_inv   = 1'b1;
        checkOutput("ign_ready", {127'd0, in_ready}, 128'd0);
        tick();
        tick();
        in_valid = 1'b0;
        waitOutValid("ign_valid");
        checkOutput("ign_data", out_data, refMix(a_st, 1'b0));
        out_ready = 1'b1;
        tick();

        // Streaming: 8 random states, in_valid and out_ready held high.
        for (int i = 0; i < 8; i++) stim[i] = randState();
        idx      = 0;
        outs     = 0;
        last_acc = -1;
        in_inv   = 1'b0;
        in_valid = 1'b1;
        in_data  = stim[0];
        for (int cyc = 0; cyc < 100 && outs < 8; cyc++) begin
            will_acc = in_valid & in_ready;
            if (will_acc) begin
                expq.push_back(refMix(stim[idx], 1'b0));
                if (last_acc >= 0) checkOutput("stream_spacing", 128'(cyc - last_acc), 128'd5);
                last_acc = cyc;
            end
            if (out_valid) begin
                if (expq.size() > 0) checkOutput("stream_data", out_data, expq.pop_front());
                else checkOutput("stream_spurious", 128'd1, 128'd0);
                outs++;
            end
            tick();
            if (will_acc) idx++;
            in_valid = (idx < 8);
            in_data  = stim[idx % 8];
        end
        in_valid = 1'b0;
        checkOutput("stream_count", 128'(outs), 128'd8);
        tick();
        out_ready = 1'b0;

        // Reset while column 2 is next to be mixed.
        a_st = randState();
        applyStimulus(a_st, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_out_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("mrst_out_data",  out_data,            128'd0);
        checkOutput("mrst_in_ready",  {127'd0, in_ready},  128'd1);
        checkOutput("mrst_busy",      {127'd0, busy},      128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        b_st = randState();
        applyStimulus(b_st, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkOutput($sformatf("mrst_latency_%0d", i), {127'd0, out_valid}, {127'd0, (i == 4)});
        end
        checkOutput("mrst_data", out_data, refMix(b_st, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
